// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller: static or scrolling 1-8 char messages.
// Optional blanking blink enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned SCROLL_DIV = 12500000,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  load_len,
  input  logic [31:0] load_data,
  input  logic        blink,
  output logic [3:0]  hex_out,
  output logic [3:0]  digit_an,
  output logic        scroll_wrap
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STATIC = 2'd2;
  localparam logic [1:0] ST_SCROLL = 2'd3;

  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
  localparam int unsigned SCROLL_W = $clog2(SCROLL_DIV);
  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [3:0] BLANK = 4'hB;

  logic [1:0]          state_q, state_d;
  logic [31:0]         buf_q, buf_d, stage_data_q, stage_data_d;
  logic [3:0]          len_q, len_d, stage_len_q, stage_len_d;
  logic [3:0]          off_q, off_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic                wrap_q, wrap_d;
  logic [3:0]          hex_q, hex_d, an_q, an_d;
  logic [1:0]          slot;
  logic [3:0]          pos, ring_n, code;
  logic                blank;

`ifdef SEG_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blank = blink && phase_q;
`else
  // Constant-false; keeps the blink port and BLINK_DIV referenced without building logic.
  assign blank = (BLINK_DIV == 0) && blink;
`endif

  assign load_ready  = (state_q != ST_LOAD);
  assign hex_out     = hex_q;
  assign digit_an    = an_q;
  assign scroll_wrap = wrap_q;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    len_d        = len_q;
    stage_data_d = stage_data_q;
    stage_len_d  = stage_len_q;
    off_d        = off_q;
    scroll_cnt_d = scroll_cnt_q;
    wrap_d       = 1'b0;

    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    idx_d      = (scan_cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;

    if (state_q == ST_SCROLL) begin
      if (scroll_cnt_q == SCROLL_LAST) begin
        scroll_cnt_d = '0;
        if (off_q == len_q) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_q + 4'd1;
        end
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end

    if (state_q == ST_LOAD) begin
      buf_d        = stage_data_q;
      len_d        = stage_len_q;
      off_d        = '0;
      scroll_cnt_d = '0;
      if (stage_len_q == 4'd0)      state_d = ST_IDLE;
      else if (stage_len_q <= 4'd4) state_d = ST_STATIC;
      else                          state_d = ST_SCROLL;
    end else if (load_valid) begin
      stage_data_d = load_data;
      stage_len_d  = (load_len > 4'd8) ? 4'd8 : load_len;
      state_d      = ST_LOAD;
    end
  end

  // Display follows the committed length, so the old message keeps showing during LOAD.
  always_comb begin
    slot   = 2'd3 - idx_q;
    ring_n = len_q + 4'd1;
    pos    = off_q + {2'b00, slot};
    if (pos >= ring_n) pos = pos - ring_n;
    code = BLANK;
    if (len_q == 4'd0) begin
      code = BLANK;
    end else if (len_q <= 4'd4) begin
      if ({2'b00, slot} < len_q) code = buf_q[{1'b0, slot, 2'b00} +: 4];
    end else begin
      if (pos < len_q) code = buf_q[{pos[2:0], 2'b00} +: 4];
    end
    hex_d = blank ? BLANK : code;
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= {8{BLANK}};
      len_q        <= '0;
      stage_data_q <= {8{BLANK}};
      stage_len_q  <= '0;
      off_q        <= '0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      scroll_cnt_q <= '0;
      wrap_q       <= 1'b0;
      hex_q        <= BLANK;
      an_q         <= 4'b1111;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      stage_data_q <= stage_data_d;
      stage_len_q  <= stage_len_d;
      off_q        <= off_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      scroll_cnt_q <= scroll_cnt_d;
      wrap_q       <= wrap_d;
      hex_q        <= hex_d;
      an_q         <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle model from elapsed-time arithmetic plus directed literal checks.
module tb_seg_scan_ctrl;
  localparam int SCAN_DIV   = 4;
  localparam int SCROLL_DIV = 64;
  localparam int BLINK_DIV  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_len = '0;
  logic [31:0] load_data = '0;
  logic        blink = 1'b0;
  logic        load_ready;
  logic [3:0]  hex_out, digit_an;
  logic        scroll_wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_len(load_len), .load_data(load_data), .blink(blink),
    .hex_out(hex_out), .digit_an(digit_an), .scroll_wrap(scroll_wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset, cycles scrolled since commit, and the committed message.
  int         m_cyc, m_since, m_len, st_len, m_k;
  bit         m_loading, m_blank;
  logic [3:0] m_msg[8];
  logic [3:0] st_msg[8];
  logic [3:0] e_hex = 4'hB;
  logic [3:0] e_an = 4'hF;
  bit         e_wrap;

  function automatic logic [3:0] show(input int k);
    int p;
    if (m_len == 0) return 4'hB;
    if (m_len <= 4) return (3 - k < m_len) ? m_msg[3 - k] : 4'hB;
    p = ((m_since / SCROLL_DIV) + 3 - k) % (m_len + 1);
    return (p < m_len) ? m_msg[p] : 4'hB;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_since = 0; m_len = 0; m_loading = 0;
      for (int i = 0; i < 8; i++) m_msg[i] = 4'hB;
      e_hex = 4'hB; e_an = 4'hF; e_wrap = 0;
    end else begin
      m_k = (m_cyc / SCAN_DIV) % 4;
      m_blank = 0;
`ifdef SEG_BLINK_EN
      m_blank = blink && ((m_cyc / BLINK_DIV) % 2 == 1);
`endif
      e_an  = m_blank ? 4'hF : ~(4'b0001 << m_k);
      e_hex = m_blank ? 4'hB : show(m_k);
      e_wrap = 0;
      if (!m_loading && m_len > 4) begin
        m_since++;
        e_wrap = (m_since % (SCROLL_DIV * (m_len + 1))) == 0;
      end
      if (m_loading) begin
        m_msg = st_msg; m_len = st_len; m_since = 0; m_loading = 0;
      end else if (load_valid) begin
        for (int i = 0; i < 8; i++) st_msg[i] = load_data[4*i +: 4];
        st_len = (load_len > 8) ? 8 : int'(load_len);
        m_loading = 1;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_hex", hex_out, e_hex);
    check("model_an", digit_an, e_an);
    check("model_wrap", scroll_wrap, e_wrap);
    check("model_ready", load_ready, !m_loading);
  end

  task automatic do_load(input logic [3:0] len, input logic [31:0] data);
    @(negedge clk);
    load_valid = 1'b1; load_len = len; load_data = data;
    @(negedge clk);
    check("ready_low", load_ready, 1'b0);
    load_valid = 1'b0;
    @(negedge clk);
    check("ready_back", load_ready, 1'b1);
  endtask

  // Expected string lists digits 3..0 as nibbles, leftmost first.
  task automatic sweep(input string name, input logic [15:0] exp_str);
    logic [3:0] ex;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (digit_an)
        4'b0111: ex = exp_str[15:12];
        4'b1011: ex = exp_str[11:8];
        4'b1101: ex = exp_str[7:4];
        default: ex = exp_str[3:0];
      endcase
      check(name, hex_out, ex);
    end
  endtask

  task automatic measure_wrap(input string name, input int period);
    int t;
    int d;
    t = 0;
    while (!scroll_wrap && t < 2000) begin @(negedge clk); t++; end
    check({name, "_seen"}, scroll_wrap, 1'b1);
    @(negedge clk);
    check({name, "_width"}, scroll_wrap, 1'b0);
    d = 1;
    while (!scroll_wrap && d < 2000) begin @(negedge clk); d++; end
    check({name, "_period"}, d, period);
  endtask

  logic [3:0] an_seq[4];
  int cnt;

  initial begin
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;
    #1 reset = 1'b1;
    #1;
    check("rst_hex", hex_out, 4'hB);
    check("rst_an", digit_an, 4'hF);
    check("rst_ready", load_ready, 1'b1);
    check("rst_wrap", scroll_wrap, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan order, four clocks per digit.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("idle_an", digit_an, an_seq[i / 4]);
      check("idle_hex", hex_out, 4'hB);
    end

    do_load(4'd2, 32'h000000C1);
    sweep("static_1C", 16'h1CBB);
    cnt = 0;
    repeat (1000) begin @(negedge clk); if (scroll_wrap) cnt++; end
    check("static_nowrap", cnt, 0);

    do_load(4'd5, 32'h000DEFA1);
    sweep("scroll_off0", 16'h1AFE);
    repeat (53) @(negedge clk);
    sweep("scroll_off1", 16'hAFED);
    repeat (50) @(negedge clk);
    sweep("scroll_off2", 16'hFEDB);
    measure_wrap("wrap5", 384);

    do_load(4'd12, 32'h87654321);
    sweep("clamp_off0", 16'h1234);
    repeat (100) @(negedge clk);
    do_load(4'd12, 32'hA9876543);
    sweep("reload_off0", 16'h3456);
    measure_wrap("wrap8", 576);

    repeat (70) @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_hex", hex_out, 4'hB);
    check("async_an", digit_an, 4'hF);
    check("async_ready", load_ready, 1'b1);
    check("async_wrap", scroll_wrap, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sweep("post_reset_idle", 16'hBBBB);

    do_load(4'd2, 32'h000000C1);
    blink = 1'b1;
    cnt = 0;
    repeat (128) begin @(negedge clk); if (digit_an == 4'hF) cnt++; end
`ifdef SEG_BLINK_EN
    check("blink_blanked", cnt, 64);
`else
    check("blink_blanked", cnt, 0);
`endif
    blink = 1'b0;
    cnt = 0;
    repeat (64) begin @(negedge clk); if (digit_an == 4'hF) cnt++; end
    check("noblink_blanked", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
